// File: rtl/regfile_mp.sv
// regfile_mp: two-write/two-read register file with optional write bypass and post-reset clear sequencer.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int AW = $clog2(NREGS),
  parameter bit BYPASS = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   read_a,
  input  logic [AW-1:0]   read_b,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  input  logic            we0,
  input  logic [AW-1:0]   widx0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            we1,
  input  logic [AW-1:0]   widx1,
  input  logic [XLEN-1:0] wdata1,
  output logic            ready
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic            run, clr_we, w0, w1;
  assign run    = state_q == RUN;
  assign clr_we = !reset && state_q == CLEAR;
  assign w0     = run && !reset && we0 && |widx0;
  // port 1 loses a same-index collision so bypass and stored values agree
  assign w1     = run && !reset && we1 && |widx1 && !(w0 && widx0 == widx1);
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + AW'(1);
      state_d   = (clr_idx_q == AW'(NREGS - 1)) ? RUN : CLEAR;
      ready_d   = clr_idx_q == AW'(NREGS - 1);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end
  always_ff @(posedge clock) begin
    if (clr_we) regs_q[clr_idx_q] <= '0;
    if (w0) regs_q[widx0] <= wdata0;
    if (w1) regs_q[widx1] <= wdata1;
  end
  function automatic logic [XLEN-1:0] rd(input logic [AW-1:0] idx);
    return (!run || reset || idx == '0) ? '0 :
           (BYPASS && w0 && widx0 == idx) ? wdata0 :
           (BYPASS && w1 && widx1 == idx) ? wdata1 : regs_q[idx];
  endfunction
  assign a     = rd(read_a);
  assign b     = rd(read_b);
  assign ready = ready_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench driving a bypass and a non-bypass register file with shared stimulus.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  read_a = '0, read_b = '0, widx0 = '0, widx1 = '0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [31:0] a, b, a_n, b_n;
  logic        ready, ready_n;
  int          tests = 0, fails = 0;
  logic [31:0] mdl [32];
  bit          run_m = 1'b0;
  typedef struct {int sel; logic [31:0] exp;} exp_t;
  exp_t        sb [$];
  string       names [6] = '{"a", "b", "a_nobyp", "b_nobyp", "ready", "ready_nobyp"};

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) u_byp (
    .clock(clk), .reset(reset), .read_a(read_a), .read_b(read_b), .a(a), .b(b),
    .we0(we0), .widx0(widx0), .wdata0(wdata0), .we1(we1), .widx1(widx1), .wdata1(wdata1),
    .ready(ready));
  regfile_mp #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) u_nobyp (
    .clock(clk), .reset(reset), .read_a(read_a), .read_b(read_b), .a(a_n), .b(b_n),
    .we0(we0), .widx0(widx0), .wdata0(wdata0), .we1(we1), .widx1(widx1), .wdata1(wdata1),
    .ready(ready_n));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int sel, input logic [31:0] exp);
    exp_t e;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] got;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = e.sel == 0 ? a : e.sel == 1 ? b : e.sel == 2 ? a_n : e.sel == 3 ? b_n :
            e.sel == 4 ? {31'd0, ready} : {31'd0, ready_n};
      check(names[e.sel], got, e.exp);
    end
  endtask

  function automatic bit v0();
    return run_m && we0 && widx0 != 0;
  endfunction
  function automatic bit v1();
    return run_m && we1 && widx1 != 0 && !(v0() && widx0 == widx1);
  endfunction
  function automatic logic [31:0] exp_byp(input logic [4:0] idx);
    if (!run_m || idx == 0) return 32'd0;
    if (v0() && widx0 == idx) return wdata0;
    if (v1() && widx1 == idx) return wdata1;
    return mdl[idx];
  endfunction
  function automatic logic [31:0] exp_st(input logic [4:0] idx);
    return (!run_m || idx == 0) ? 32'd0 : mdl[idx];
  endfunction

  // one clock cycle with reset low: drive, predict, compare mid-cycle, commit to the model
  task automatic step(input bit e0, input logic [4:0] i0, input logic [31:0] d0,
                      input bit e1, input logic [4:0] i1, input logic [31:0] d1,
                      input logic [4:0] ra, input logic [4:0] rb);
    bit c0, c1;
    we0 = e0; widx0 = i0; wdata0 = d0;
    we1 = e1; widx1 = i1; wdata1 = d1;
    read_a = ra; read_b = rb;
    push(0, exp_byp(ra)); push(1, exp_byp(rb));
    push(2, exp_st(ra));  push(3, exp_st(rb));
    push(4, {31'd0, run_m}); push(5, {31'd0, run_m});
    c0 = v0(); c1 = v1();
    drain();
    @(posedge clk);
    if (c0) mdl[i0] = d0;
    if (c1) mdl[i1] = d1;
    #1;
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
  endtask

  task automatic rst_cycles(input int n);
    reset = 1'b1;
    read_a = 5'd4; read_b = 5'd5;
    repeat (n) begin
      @(posedge clk);
      #1;
      push(0, 32'd0); push(1, 32'd0); push(4, 32'd0); push(5, 32'd0);
      drain();
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_m = 1'b0;
  endtask

  // ready must stay low for NREGS samples, then every register is zero; a write at idx 3 late in CLEAR is dropped
  task automatic clear_seq();
    for (int i = 0; i < 32; i++)
      if (i == 20) step(1'b1, 5'd3, 32'h55, 1'b1, 5'd6, 32'h66, 5'(i), 5'd3);
      else idle(5'(i), 5'd3);
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    run_m = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    rst_cycles(3);
    clear_seq();
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    idle(5'd5, 5'd0);
    step(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 5'd5, 5'd7);
    idle(5'd7, 5'd7);
    idle(5'd5, 5'd7);
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hAAAA5555, 5'd0, 5'd5);
    idle(5'd0, 5'd7);
    step(1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    idle(5'd9, 5'd9);
    step(1'b0, 5'd12, 32'h999, 1'b1, 5'd12, 32'hCAFE, 5'd12, 5'd9);
    step(1'b1, 5'd20, 32'hA0A0, 1'b1, 5'd21, 32'hB1B1, 5'd20, 5'd21);
    step(1'b1, 5'd0, 32'h77, 1'b1, 5'd22, 32'h2222, 5'd22, 5'd0);
    idle(5'd21, 5'd22);
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 5'($urandom_range(0, 7)), $urandom, 1'($urandom),
           5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    step(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    rst_cycles(3);
    for (int i = 0; i < 10; i++) idle(5'(i), 5'd3);
    rst_cycles(1);
    clear_seq();
    for (int i = 0; i < 32; i++) idle(5'(i), 5'd3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the core's integer register file.
- Generalised in data width and register count, with two write ports and two combinational read ports.
- Adds optional same-cycle write-to-read bypass and a post-reset clear sequencer, so every register reads zero before first use.
- Sits between decode (read ports) and writeback; write port 0 is the main writeback and write port 1 is the long-latency unit (load/mul).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=4); register 0 hardwired to zero
AW, $clog2(NREGS), index width (derived; not overridden)
BYPASS, 1, 1 = read ports return same-cycle write data; 0 = reads return stored value only

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
read_a  in  AW  read port A index
read_b  in  AW  read port B index
a  out  XLEN  read port A data (combinational)
b  out  XLEN  read port B data (combinational)
we0  in  1  write enable, port 0 (high priority)
widx0  in  AW  write index, port 0
wdata0  in  XLEN  write data, port 0
we1  in  1  write enable, port 1 (low priority)
widx1  in  AW  write index, port 1
wdata1  in  XLEN  write data, port 1
ready  out  1  high when the file accepts writes and returns stored data

Behaviour:
- One clock; reset is synchronous and active-high. All state changes occur on the rising edge of clock.
- FSM has two states, CLEAR and RUN, with a clear index clr_idx (AW bits).
- Reset asserted: next state CLEAR, clr_idx <= 0, ready <= 0. Reset dominates all other inputs.
- CLEAR state, each cycle reset is low:
  - regs[clr_idx] <= 0 and clr_idx <= clr_idx+1.
  - When clr_idx == NREGS-1, the next state is RUN and ready <= 1.
  - ready therefore rises exactly NREGS cycles after the first edge with reset low.
- Reset reasserted mid-CLEAR or in RUN: return to CLEAR with clr_idx=0 (full restart).
- In CLEAR: we0/we1 are ignored (dropped, not queued), and a and b read 0 regardless of index.
- In RUN, writes:
  - Port 0 write when we0 and widx0 != 0.
  - Port 1 write when we1 and widx1 != 0, unless port 0 writes the same index in that cycle. On collision port 0 wins and port 1 data is discarded.
  - Writes become visible in the stored array on the next edge.
- Reads (combinational, RUN):
  - Index 0 always reads 0, including when a write targets index 0.
  - BYPASS=1: if a valid port-0 write matches the read index, return wdata0. Otherwise, if a valid port-1 write matches, return wdata1. Otherwise return stored data. Same priority as the write path, so bypassed and later-stored values agree.
  - BYPASS=0: always return the stored value; the new value appears the cycle after the write.
- Reset values: ready=0. a=b=0 throughout reset and CLEAR. All registers are 0 when ready first rises.
- No X may propagate: indices are always in range because NREGS is a power of two.

Test Plan:
- Reset held 3 cycles, then released: ready is low for exactly 32 cycles (NREGS=32), high on the 33rd. Reading every index 0..31 afterwards returns 0.
- RUN, BYPASS=1: we0=1, widx0=5, wdata0=0xDEADBEEF, read_a=5 in the same cycle -> a=0xDEADBEEF in that cycle. Next cycle with we0=0 -> a still 0xDEADBEEF.
- Collision: we0=1 and we1=1, both targeting idx 7, wdata0=0x11, wdata1=0x22 -> b (read_b=7) reads 0x11 in the same cycle and in all following cycles.
- Writes to x0: we0=1, widx0=0, wdata0=0xFFFFFFFF and we1=1, widx1=0 -> a reads 0 in the same cycle and the next. No other register changes.
- Reset mid-clear: assert reset when clr_idx=10 for 1 cycle -> ready rises 32 cycles after release, not 22. A write issued during CLEAR (idx 3 = 0x55) is dropped, so idx 3 reads 0 after ready.
- BYPASS=0 build: write idx 9 = 0x1234 while reading idx 9 -> old value (0) that cycle, 0x1234 the next.
